multi_button_debouncer: RTL

//   Parametrised successor to the single-button debouncer. Debounces NUM_BTNS

---
 rtl/multi_button_debouncer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/multi_button_debouncer.sv
// Multi-channel push-button debouncer: per channel a synchroniser, a stability-count level
// filter, one-cycle rise/fall pulses and a long-press / auto-repeat hold pulse.
module mbd_channel #(
    parameter int STABLE_SAMPLES = 4,
    parameter int HOLD_SAMPLES   = 16,
    parameter int REPEAT_SAMPLES = 4
) (
    input  logic sampling_clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic hold_pulse,
    output logic held
);
    localparam int SW   = $clog2(STABLE_SAMPLES + 1);
    localparam int HMAX = (HOLD_SAMPLES > REPEAT_SAMPLES) ? HOLD_SAMPLES : REPEAT_SAMPLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SAMPLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_SAMPLES > 0) ? REPEAT_SAMPLES - 1 : 0);
    localparam logic [HW-1:0] CNT_MAX   = HW'(HMAX);

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic [SW-1:0]   stab_q, stab_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            level_d, rising, falling, hold_hit;

    always_comb begin
        stab_d  = '0;
        level_d = level;
        if (sync_q[1] != level) begin
            if (stab_q == STAB_LAST) level_d = ~level;
            else                     stab_d  = stab_q + SW'(1);
        end
    end

    assign rising  = ~level & level_d;
    assign falling = level & ~level_d;

    // A fall on the same edge as a would-be hold hit suppresses the hit.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        hold_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (rising) state_d = PRESSED;
            end
            PRESSED: begin
                if (falling) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_hit   = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = HELD;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            HELD: begin
                if (falling) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end else if (REPEAT_SAMPLES > 0 && hold_cnt_q == REP_LAST) begin
                    hold_hit   = 1'b1;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sampling_clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            stab_q     <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            hold_pulse <= 1'b0;
            hold_cnt_q <= '0;
            state_q    <= IDLE;
        end else begin
            sync_q     <= {sync_q[0], btn};
            stab_q     <= stab_d;
            level      <= level_d;
            rise_pulse <= rising;
            fall_pulse <= falling;
            hold_pulse <= hold_hit;
            hold_cnt_q <= hold_cnt_d;
            state_q    <= state_d;
        end
    end

    assign held = (state_q == HELD);
endmodule

module multi_button_debouncer #(
    parameter int NUM_BTNS       = 4,
    parameter int STABLE_SAMPLES = 4,
    parameter int HOLD_SAMPLES   = 16,
    parameter int REPEAT_SAMPLES = 4
) (
    input  logic                sampling_clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn,
    output logic [NUM_BTNS-1:0] level,
    output logic [NUM_BTNS-1:0] rise_pulse,
    output logic [NUM_BTNS-1:0] fall_pulse,
    output logic [NUM_BTNS-1:0] hold_pulse,
    output logic [NUM_BTNS-1:0] held
);
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        mbd_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES),
            .HOLD_SAMPLES  (HOLD_SAMPLES),
            .REPEAT_SAMPLES(REPEAT_SAMPLES)
        ) u_ch (
            .sampling_clk(sampling_clk),
            .rst         (rst),
            .btn         (btn[i]),
            .level       (level[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .hold_pulse  (hold_pulse[i]),
            .held        (held[i])
        );
    end
endmodule
